// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges two never-stalled ALU results with round-robin
// mul/div and load results onto two registered register-file write ports.
module wb_port #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_OUT_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      en,
  input  logic [4:0]                rd,
  input  logic [DATA_WIDTH-1:0]     data,
  output logic                      write_en,
  output logic [ADDR_OUT_WIDTH-1:0] write_addr,
  output logic [DATA_WIDTH-1:0]     write_data
);
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      write_en   <= 1'b0;
      write_addr <= '0;
      write_data <= '0;
    end else begin
      write_en <= en;
      // an idle port keeps its last address/data
      if (en) begin
        write_addr <= {{(ADDR_OUT_WIDTH-5){1'b0}}, rd};
        write_data <= data;
      end
    end
  end
endmodule

module wb_arbiter #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_OUT_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      src0_valid,
  input  logic [4:0]                src0_rd,
  input  logic [DATA_WIDTH-1:0]     src0_data,
  input  logic                      src1_valid,
  input  logic [4:0]                src1_rd,
  input  logic [DATA_WIDTH-1:0]     src1_data,
  input  logic                      src2_valid,
  input  logic [4:0]                src2_rd,
  input  logic [DATA_WIDTH-1:0]     src2_data,
  output logic                      src2_ready,
  input  logic                      src3_valid,
  input  logic [4:0]                src3_rd,
  input  logic [DATA_WIDTH-1:0]     src3_data,
  output logic                      src3_ready,
  output logic                      write_en_0,
  output logic [ADDR_OUT_WIDTH-1:0] write_addr_0,
  output logic [DATA_WIDTH-1:0]     write_data_0,
  output logic                      write_en_1,
  output logic [ADDR_OUT_WIDTH-1:0] write_addr_1,
  output logic [DATA_WIDTH-1:0]     write_data_1,
  output logic                      rr_ptr
);
  typedef struct packed {
    logic                  vld;
    logic [4:0]            rd;
    logic [DATA_WIDTH-1:0] data;
  } res_t;

  res_t [1:0]                  mres;   // 0 = mul/div, 1 = load
  logic [1:0]                  g_en;
  logic [1:0][4:0]             g_rd;
  logic [1:0][DATA_WIDTH-1:0]  g_data;
  logic [1:0]                  m_acc;
  logic [1:0]                  nslot;
  logic                        w0, w1, idx, clash;

  assign mres[0] = {src2_valid, src2_rd, src2_data};
  assign mres[1] = {src3_valid, src3_rd, src3_data};

  always_comb begin
    g_en   = '0;
    g_rd   = '0;
    g_data = '0;
    m_acc  = '0;
    nslot  = 2'd0;
    idx    = 1'b0;
    clash  = 1'b0;
    // eu1 is younger: on a shared rd its result supersedes eu0's
    w0 = src0_valid && (src0_rd != 5'd0) && !(src1_valid && (src1_rd == src0_rd));
    w1 = src1_valid && (src1_rd != 5'd0);
    if (w0) begin
      g_en[0]   = 1'b1;
      g_rd[0]   = src0_rd;
      g_data[0] = src0_data;
      nslot     = 2'd1;
    end
    if (w1) begin
      g_en[nslot[0]]   = 1'b1;
      g_rd[nslot[0]]   = src1_rd;
      g_data[nslot[0]] = src1_data;
      nslot            = nslot + 2'd1;
    end
    for (int k = 0; k < 2; k++) begin
      idx   = rr_ptr ^ k[0];
      clash = (g_en[0] && (g_rd[0] == mres[idx].rd)) ||
              (g_en[1] && (g_rd[1] == mres[idx].rd));
      if (mres[idx].vld) begin
        if (mres[idx].rd == 5'd0) begin
          m_acc[idx] = 1'b1;
        end else if (!clash && (nslot != 2'd2)) begin
          m_acc[idx]       = 1'b1;
          g_en[nslot[0]]   = 1'b1;
          g_rd[nslot[0]]   = mres[idx].rd;
          g_data[nslot[0]] = mres[idx].data;
          nslot            = nslot + 2'd1;
        end
      end
    end
  end

  assign src2_ready = rstn & m_acc[0];
  assign src3_ready = rstn & m_acc[1];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) rr_ptr <= 1'b0;
    else       rr_ptr <= rr_ptr ^ m_acc[rr_ptr];
  end

  logic [1:0]                     p_en;
  logic [1:0][ADDR_OUT_WIDTH-1:0] p_addr;
  logic [1:0][DATA_WIDTH-1:0]     p_data;

  for (genvar p = 0; p < 2; p++) begin : g_port
    wb_port #(.DATA_WIDTH(DATA_WIDTH), .ADDR_OUT_WIDTH(ADDR_OUT_WIDTH)) u_port (
      .clk        (clk),
      .rstn       (rstn),
      .en         (g_en[p]),
      .rd         (g_rd[p]),
      .data       (g_data[p]),
      .write_en   (p_en[p]),
      .write_addr (p_addr[p]),
      .write_data (p_data[p])
    );
  end

  assign write_en_0   = p_en[0];
  assign write_addr_0 = p_addr[0];
  assign write_data_0 = p_data[0];
  assign write_en_1   = p_en[1];
  assign write_addr_1 = p_addr[1];
  assign write_data_1 = p_data[1];
endmodule

// File: tb/tb_wb_arbiter.sv
// Directed vector bench for wb_arbiter: table of single-cycle cases plus
// reset sequences.
module tb_wb_arbiter;
  logic        clk = 1'b0;
  logic        rstn;
  logic        src0_valid, src1_valid, src2_valid, src3_valid;
  logic [4:0]  src0_rd, src1_rd, src2_rd, src3_rd;
  logic [31:0] src0_data, src1_data, src2_data, src3_data;
  logic        src2_ready, src3_ready;
  logic        write_en_0, write_en_1, rr_ptr;
  logic [31:0] write_addr_0, write_addr_1, write_data_0, write_data_1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_arbiter dut (
    .clk(clk), .rstn(rstn),
    .src0_valid(src0_valid), .src0_rd(src0_rd), .src0_data(src0_data),
    .src1_valid(src1_valid), .src1_rd(src1_rd), .src1_data(src1_data),
    .src2_valid(src2_valid), .src2_rd(src2_rd), .src2_data(src2_data), .src2_ready(src2_ready),
    .src3_valid(src3_valid), .src3_rd(src3_rd), .src3_data(src3_data), .src3_ready(src3_ready),
    .write_en_0(write_en_0), .write_addr_0(write_addr_0), .write_data_0(write_data_0),
    .write_en_1(write_en_1), .write_addr_1(write_addr_1), .write_data_1(write_data_1),
    .rr_ptr(rr_ptr)
  );

  typedef struct {
    logic [3:0]       v;
    logic [3:0][4:0]  rd;
    logic [3:0][31:0] d;
    logic             r2, r3;
    logic             e0, e1;
    logic [31:0]      a0, d0, a1, d1;
    logic             rr;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic [3:0] v,
                     input logic [4:0] rd0, input logic [31:0] d0,
                     input logic [4:0] rd1, input logic [31:0] d1,
                     input logic [4:0] rd2, input logic [31:0] d2,
                     input logic [4:0] rd3, input logic [31:0] d3,
                     input logic r2, input logic r3,
                     input logic e0, input logic [31:0] a0, input logic [31:0] o0,
                     input logic e1, input logic [31:0] a1, input logic [31:0] o1,
                     input logic rr);
    vec_t t;
    t.v = v;
    t.rd = {rd3, rd2, rd1, rd0};
    t.d  = {d3, d2, d1, d0};
    t.r2 = r2; t.r3 = r3;
    t.e0 = e0; t.a0 = a0; t.d0 = o0;
    t.e1 = e1; t.a1 = a1; t.d1 = o1;
    t.rr = rr;
    tbl.push_back(t);
  endtask

  task automatic drive(input logic [3:0] v, input logic [3:0][4:0] rd, input logic [3:0][31:0] d);
    src0_valid = v[0]; src0_rd = rd[0]; src0_data = d[0];
    src1_valid = v[1]; src1_rd = rd[1]; src1_data = d[1];
    src2_valid = v[2]; src2_rd = rd[2]; src2_data = d[2];
    src3_valid = v[3]; src3_rd = rd[3]; src3_data = d[3];
  endtask

  task automatic idle();
    drive(4'b0000, '0, '0);
  endtask

  initial begin
    //   v     rd0 d0     rd1 d1     rd2 d2     rd3 d3     r2 r3  e0 a0 d0      e1 a1  d1      rr
    add(4'b0111, 3, 'h11,  4, 'h22,  5, 'h55,  0, 0,      0, 0,  1, 3, 'h11,  1, 4,  'h22,  0);
    add(4'b0100, 0, 0,     0, 0,     5, 'h55,  0, 0,      1, 0,  1, 5, 'h55,  0, 4,  'h22,  1);
    add(4'b1011, 7, 'hA,   7, 'hB,   0, 0,     9, 'hC,    0, 1,  1, 7, 'hB,   1, 9,  'hC,   0);
    add(4'b1100, 0, 0,     0, 0,     2, 'h20,  6, 'h60,   1, 1,  1, 2, 'h20,  1, 6,  'h60,  1);
    add(4'b1100, 0, 0,     0, 0,     2, 'h20,  6, 'h60,   1, 1,  1, 6, 'h60,  1, 2,  'h20,  0);
    add(4'b1100, 0, 0,     0, 0,     2, 'h20,  6, 'h60,   1, 1,  1, 2, 'h20,  1, 6,  'h60,  1);
    add(4'b1101, 1, 'h10,  0, 0,     6, 'h26,  6, 'h36,   0, 1,  1, 1, 'h10,  1, 6,  'h36,  0);
    add(4'b1101, 1, 'h10,  0, 0,     6, 'h26,  6, 'h36,   1, 0,  1, 1, 'h10,  1, 6,  'h26,  1);
    add(4'b1101, 1, 'h10,  0, 0,     6, 'h26,  6, 'h36,   0, 1,  1, 1, 'h10,  1, 6,  'h36,  0);
    add(4'b0111, 0, 'h99,  1, 'h5,   2, 'h6,   0, 0,      1, 0,  1, 1, 'h5,   1, 2,  'h6,   1);
    add(4'b1000, 0, 0,     0, 0,     0, 0,     0, 'h77,   0, 1,  0, 1, 'h5,   0, 2,  'h6,   0);
    add(4'b1101, 8, 'h80,  0, 0,     8, 'h82,  10, 'hA3,  0, 1,  1, 8, 'h80,  1, 10, 'hA3,  0);
    add(4'b0000, 0, 0,     0, 0,     0, 0,     0, 0,      0, 0,  0, 8, 'h80,  0, 10, 'hA3,  0);
    add(4'b0111, 3, 'h33,  4, 'h44,  0, 'h1,   0, 0,      1, 0,  1, 3, 'h33,  1, 4,  'h44,  1);
    add(4'b1111, 3, 'h13,  4, 'h14,  5, 'h15,  6, 'h16,   0, 0,  1, 3, 'h13,  1, 4,  'h14,  1);

    rstn = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    #1;
    chk("rst.en0", {31'b0, write_en_0}, 0);
    chk("rst.addr0", write_addr_0, 0);
    chk("rst.data0", write_data_0, 0);
    chk("rst.en1", {31'b0, write_en_1}, 0);
    chk("rst.addr1", write_addr_1, 0);
    chk("rst.data1", write_data_1, 0);
    chk("rst.rr", {31'b0, rr_ptr}, 0);
    src2_valid = 1'b1; src2_rd = 5'd5;
    #1;
    chk("rst.ready2", {31'b0, src2_ready}, 0);
    @(negedge clk);
    idle();
    rstn = 1'b1;

    foreach (tbl[i]) begin
      @(negedge clk);
      drive(tbl[i].v, tbl[i].rd, tbl[i].d);
      #1;
      chk($sformatf("v%0d.ready2", i), {31'b0, src2_ready}, {31'b0, tbl[i].r2});
      chk($sformatf("v%0d.ready3", i), {31'b0, src3_ready}, {31'b0, tbl[i].r3});
      @(posedge clk);
      #1;
      chk($sformatf("v%0d.en0", i), {31'b0, write_en_0}, {31'b0, tbl[i].e0});
      chk($sformatf("v%0d.addr0", i), write_addr_0, tbl[i].a0);
      chk($sformatf("v%0d.data0", i), write_data_0, tbl[i].d0);
      chk($sformatf("v%0d.en1", i), {31'b0, write_en_1}, {31'b0, tbl[i].e1});
      chk($sformatf("v%0d.addr1", i), write_addr_1, tbl[i].a1);
      chk($sformatf("v%0d.data1", i), write_data_1, tbl[i].d1);
      chk($sformatf("v%0d.rr", i), {31'b0, rr_ptr}, {31'b0, tbl[i].rr});
    end

    // async reset mid-cycle with a pending mul/div result
    @(negedge clk);
    idle();
    src0_valid = 1'b1; src0_rd = 5'd12; src0_data = 32'hC0;
    @(posedge clk);
    #1;
    chk("ar.en0_before", {31'b0, write_en_0}, 1);
    src0_valid = 1'b0;
    src2_valid = 1'b1; src2_rd = 5'd5; src2_data = 32'h5A;
    #1;
    rstn = 1'b0;
    #1;
    chk("ar.en0", {31'b0, write_en_0}, 0);
    chk("ar.addr0", write_addr_0, 0);
    chk("ar.data0", write_data_0, 0);
    chk("ar.en1", {31'b0, write_en_1}, 0);
    chk("ar.addr1", write_addr_1, 0);
    chk("ar.data1", write_data_1, 0);
    chk("ar.rr", {31'b0, rr_ptr}, 0);
    chk("ar.ready2", {31'b0, src2_ready}, 0);
    @(posedge clk);
    #1;
    chk("ar.held_en0", {31'b0, write_en_0}, 0);
    @(negedge clk);
    rstn = 1'b1;
    #1;
    chk("ar.ready2_rel", {31'b0, src2_ready}, 1);
    @(posedge clk);
    #1;
    chk("ar.post_en0", {31'b0, write_en_0}, 1);
    chk("ar.post_addr0", write_addr_0, 5);
    chk("ar.post_data0", write_data_0, 32'h5A);
    chk("ar.post_en1", {31'b0, write_en_1}, 0);
    chk("ar.post_rr", {31'b0, rr_ptr}, 1);
    @(negedge clk);
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
